// File: rtl/sort_pkg.sv
// Shared types and defaults for the parameterised batch sorter.
package sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 8;

endpackage

// File: rtl/param_sorter_if.sv
// Control, load-stream and result-stream bundle between a batch producer and the sorter.
interface param_sorter_if
    import sort_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              start;
    logic              descending;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, descending, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, descending, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/sort_cas.sv
// Combinational compare-and-swap of one adjacent pair; equal values are never swapped.
module sort_cas
    import sort_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_en,
    input  logic              i_desc,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b
);

    logic w_swap;

    assign w_swap = i_en && (i_desc ? (i_a < i_b) : (i_a > i_b));
    assign o_a    = w_swap ? i_b : i_a;
    assign o_b    = w_swap ? i_a : i_b;

endmodule

// File: rtl/param_sorter.sv
// Batch sorter: loads DEPTH elements, runs DEPTH odd-even transposition phases,
// then streams the sorted batch out with out_last on the final element.
module param_sorter
    import sort_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    param_sorter_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    if (DEPTH < 2) begin : g_depth_check
        $error("param_sorter: DEPTH must be 2 or more");
    end

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_phase;
    logic              r_desc;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_next  [DEPTH];
    logic [DATA_W-1:0] w_cas_a [DEPTH-1];
    logic [DATA_W-1:0] w_cas_b [DEPTH-1];
    logic [DEPTH-2:0]  w_en;
    logic [IDX_W-1:0]  w_idx_inc;

    assign w_idx_inc = r_idx + 1'b1;

    // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)...
    for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cas
        localparam logic PAR = 1'(g % 2);

        assign w_en[g] = (r_phase[0] == PAR);

        sort_cas #(
            .DATA_W (DATA_W)
        ) u_cas (
            .i_a    (r_mem[g]),
            .i_b    (r_mem[g+1]),
            .i_en   (w_en[g]),
            .i_desc (r_desc),
            .o_a    (w_cas_a[g]),
            .o_b    (w_cas_b[g])
        );
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = r_mem[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_en[i]) begin
                w_next[i]   = w_cas_a[i];
                w_next[i+1] = w_cas_b[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && bus.in_valid && r_in_ready) begin
            r_mem[r_idx] <= bus.in_data;
        end else if (r_state == ST_SORT) begin
            r_mem <= w_next;
        end
    end

    // DRAIN spends its first cycle fetching element 0, then streams without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_phase     <= '0;
            r_desc      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_LOAD;
                        r_desc     <= bus.descending;
                        r_idx      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid && r_in_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state    <= ST_SORT;
                            r_phase    <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                ST_SORT: begin
                    if (r_phase == LAST_IDX) begin
                        r_state <= ST_DRAIN;
                        r_idx   <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_mem[r_idx];
                        r_out_last  <= (r_idx == LAST_IDX);
                    end else if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_out_data <= r_mem[w_idx_inc];
                            r_out_last <= (w_idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_param_sorter.sv
// Directed bench for param_sorter: DEPTH=8 main instance plus a DEPTH=2 instance.
module tb_param_sorter;

    typedef logic [7:0] vec8_t [8];

    logic clk;
    logic rst_n;
    int   cyc;
    int   done_cnt8;
    int   tests_run;
    int   tests_failed;

    param_sorter_if #(.DATA_W(8)) bus8 ();
    param_sorter_if #(.DATA_W(8)) bus2 ();

    param_sorter #(.DATA_W(8), .DEPTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    param_sorter #(.DATA_W(8), .DEPTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial done_cnt8 = 0;
    always @(posedge clk) if (bus8.done === 1'b1) done_cnt8 <= done_cnt8 + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_batch8(input logic desc);
        bus8.start      = 1'b1;
        bus8.descending = desc;
        @(posedge clk); #1;
        bus8.start      = 1'b0;
    endtask

    // Drives one full batch; last_edge is the cycle number of the final load handshake.
    task automatic load8(input vec8_t d, input bit gaps, output int last_edge, output bit ok);
        bit hs;
        int budget;
        ok        = 1'b1;
        last_edge = -1;
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                bus8.in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            bus8.in_valid = 1'b1;
            bus8.in_data  = d[i];
            hs     = 1'b0;
            budget = 20;
            while (!hs && budget > 0) begin
                hs = bus8.in_ready;
                @(posedge clk); #1;
                budget--;
            end
            if (!hs) ok = 1'b0;
            last_edge = cyc;
        end
        bus8.in_valid = 1'b0;
    endtask

    task automatic drain8(output vec8_t res, output logic [7:0] lmask, output int first_edge, output int n);
        int budget;
        bus8.out_ready = 1'b1;
        n          = 0;
        first_edge = -1;
        lmask      = '0;
        budget     = 200;
        while (n < 8 && budget > 0) begin
            if (bus8.out_valid === 1'b1) begin
                if (first_edge < 0) first_edge = cyc;
                res[n]   = bus8.out_data;
                lmask[n] = bus8.out_last;
                n++;
            end
            @(posedge clk); #1;
            budget--;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        tests_run++; if (bus8.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus8.busy); end
        tests_run++; if (bus8.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus8.in_ready); end
        tests_run++; if (bus8.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus8.out_valid); end
        tests_run++; if (bus8.out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last: got %b expected 0", bus8.out_last); end
        tests_run++; if (bus8.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus8.done); end
        tests_run++; if (bus8.out_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 00", bus8.out_data); end
        tests_run++; if (bus2.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy_d2: got %b expected 0", bus2.busy); end
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_sorted(input string name, input logic desc, input vec8_t d, input vec8_t exp);
        vec8_t      res;
        logic [7:0] lmask;
        int         last_edge, first_edge, n, dbefore;
        bit         ok;
        dbefore = done_cnt8;
        start_batch8(desc);
        load8(d, 1'b0, last_edge, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_load: in_ready never seen within budget", name); end
        drain8(res, lmask, first_edge, n);
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL %s_count: got %0d results expected 8", name, n); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (res[i] !== exp[i]) begin tests_failed++; $display("[TB] FAIL %s_data[%0d]: got %h expected %h", name, i, res[i], exp[i]); end
        end
        tests_run++; if (lmask !== 8'h80) begin tests_failed++; $display("[TB] FAIL %s_last: got mask %b expected 10000000", name, lmask); end
        tests_run++; if (first_edge !== last_edge + 9) begin tests_failed++; $display("[TB] FAIL %s_latency: got edge %0d expected %0d", name, first_edge, last_edge + 9); end
        repeat (2) begin @(posedge clk); #1; end
        tests_run++; if (done_cnt8 - dbefore !== 1) begin tests_failed++; $display("[TB] FAIL %s_done: got %0d pulses expected 1", name, done_cnt8 - dbefore); end
    endtask

    task automatic test_ascending();
        run_sorted("asc", 1'b0, '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4},
                   '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9});
    endtask

    task automatic test_descending();
        run_sorted("desc", 1'b1, '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4},
                   '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    endtask

    task automatic test_all_equal();
        run_sorted("equal", 1'b0, '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA},
                   '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA});
    endtask

    task automatic test_gaps_backpressure();
        vec8_t      d, refv, res;
        logic [7:0] lmask, tmp;
        int         last_edge, first_edge, n, budget;
        bit         ok, stalled;
        d = '{8'd200, 8'd17, 8'd17, 8'd99, 8'd0, 8'd255, 8'd42, 8'd128};
        refv = d;
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0 && refv[j-1] > refv[j]; j--) begin
                tmp       = refv[j];
                refv[j]   = refv[j-1];
                refv[j-1] = tmp;
            end
        end
        start_batch8(1'b0);
        load8(d, 1'b1, last_edge, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_load: in_ready never seen within budget"); end
        bus8.out_ready = 1'b1;
        n = 0; first_edge = -1; budget = 300; stalled = 1'b0; lmask = '0;
        while (n < 8 && budget > 0) begin
            if (bus8.out_valid === 1'b1) begin
                if (first_edge < 0) first_edge = cyc;
                if (n == 3 && !stalled) begin
                    stalled = 1'b1;
                    bus8.out_ready = 1'b0;
                    repeat (5) begin
                        @(posedge clk); #1;
                        tests_run++;
                        if (bus8.out_valid !== 1'b1 || bus8.out_data !== refv[3] || bus8.out_last !== 1'b0) begin
                            tests_failed++;
                            $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b expected valid=1 data=%h last=0",
                                     bus8.out_valid, bus8.out_data, bus8.out_last, refv[3]);
                        end
                    end
                    bus8.out_ready = 1'b1;
                end
                res[n]   = bus8.out_data;
                lmask[n] = bus8.out_last;
                n++;
            end
            @(posedge clk); #1;
            budget--;
        end
        tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL gaps_count: got %0d results expected 8", n); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (res[i] !== refv[i]) begin tests_failed++; $display("[TB] FAIL gaps_data[%0d]: got %h expected %h", i, res[i], refv[i]); end
        end
        tests_run++; if (lmask !== 8'h80) begin tests_failed++; $display("[TB] FAIL gaps_last: got mask %b expected 10000000", lmask); end
        tests_run++; if (first_edge !== last_edge + 9) begin tests_failed++; $display("[TB] FAIL gaps_latency: got edge %0d expected %0d", first_edge, last_edge + 9); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sort();
        vec8_t      res2;
        logic [1:0] lmask2;
        int         last_edge, bad, n, budget;
        bit         ok, hs;
        start_batch8(1'b0);
        load8('{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4}, 1'b0, last_edge, ok);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus8.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus8.busy); end
        tests_run++; if (bus8.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", bus8.out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) bad++;
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL midreset_stale: got %0d active cycles expected 0", bad); end

        bus2.start = 1'b1;
        bus2.descending = 1'b0;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = (i == 0) ? 8'hFF : 8'h00;
            hs = 1'b0; budget = 20;
            while (!hs && budget > 0) begin
                hs = bus2.in_ready;
                @(posedge clk); #1;
                budget--;
            end
            tests_run++; if (hs !== 1'b1) begin tests_failed++; $display("[TB] FAIL d2_load[%0d]: in_ready never seen within budget", i); end
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        n = 0; budget = 40; lmask2 = '0;
        while (n < 2 && budget > 0) begin
            if (bus2.out_valid === 1'b1) begin
                res2[n]   = bus2.out_data;
                lmask2[n] = bus2.out_last;
                n++;
            end
            @(posedge clk); #1;
            budget--;
        end
        tests_run++; if (n !== 2) begin tests_failed++; $display("[TB] FAIL d2_count: got %0d results expected 2", n); end
        tests_run++; if (res2[0] !== 8'h00) begin tests_failed++; $display("[TB] FAIL d2_data[0]: got %h expected 00", res2[0]); end
        tests_run++; if (res2[1] !== 8'hFF) begin tests_failed++; $display("[TB] FAIL d2_data[1]: got %h expected ff", res2[1]); end
        tests_run++; if (lmask2 !== 2'b10) begin tests_failed++; $display("[TB] FAIL d2_last: got mask %b expected 10", lmask2); end
        @(posedge clk); #1;
    endtask

    // start stays high through a whole batch with descending flipped after the opening edge.
    task automatic test_start_ignored();
        vec8_t      d, res;
        logic [7:0] lmask;
        int         last_edge, first_edge, n;
        bit         ok;
        vec8_t      exp_asc, exp_desc;
        d        = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
        exp_asc  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
        exp_desc = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        bus8.start      = 1'b1;
        bus8.descending = 1'b0;
        @(posedge clk); #1;
        bus8.descending = 1'b1;
        tests_run++; if (bus8.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_open: got in_ready %b expected 1", bus8.in_ready); end
        load8(d, 1'b0, last_edge, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_load: in_ready never seen within budget"); end
        drain8(res, lmask, first_edge, n);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (res[i] !== exp_asc[i]) begin tests_failed++; $display("[TB] FAIL start_ignored_data[%0d]: got %h expected %h", i, res[i], exp_asc[i]); end
        end
        tests_run++; if (first_edge !== last_edge + 9) begin tests_failed++; $display("[TB] FAIL start_ignored_latency: got edge %0d expected %0d", first_edge, last_edge + 9); end
        tests_run++; if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_cycle: got done=%b busy=%b expected done=1 busy=0", bus8.done, bus8.busy); end
        @(posedge clk); #1;
        bus8.start = 1'b0;
        tests_run++; if (bus8.in_ready !== 1'b1 || bus8.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_restart: got in_ready=%b busy=%b expected 1 1", bus8.in_ready, bus8.busy); end
        load8(d, 1'b0, last_edge, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_load: in_ready never seen within budget"); end
        drain8(res, lmask, first_edge, n);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (res[i] !== exp_desc[i]) begin tests_failed++; $display("[TB] FAIL restart_data[%0d]: got %h expected %h", i, res[i], exp_desc[i]); end
        end
        tests_run++; if (lmask !== 8'h80) begin tests_failed++; $display("[TB] FAIL restart_last: got mask %b expected 10000000", lmask); end
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b1;
        bus8.start      = 1'b0;
        bus8.descending = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.in_data    = '0;
        bus8.out_ready  = 1'b0;
        bus2.start      = 1'b0;
        bus2.descending = 1'b0;
        bus2.in_valid   = 1'b0;
        bus2.in_data    = '0;
        bus2.out_ready  = 1'b0;

        test_reset();
        test_ascending();
        test_descending();
        test_all_equal();
        test_gaps_backpressure();
        test_reset_mid_sort();
        test_start_ignored();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
